// File: rtl/branch_rs.sv
`default_nettype none
// ============================================================================
// Module   : branch_rs
// Purpose  : Branch reservation station. Collapsing queue of DEPTH entries
//            (entry 0 oldest). Holds branches until both operands are ready,
//            captures operands from the common data bus, and issues the
//            oldest ready entry to the branch unit each cycle.
// Ports    : clk, rst_n (async, active low)
//            disp_*  - dispatch request/handshake and operand fields
//            cdb_*   - common data bus broadcast (wakeup)
//            flush   - squash all entries
//            iss_*   - issue to branch unit (combinational from state)
//            count   - occupied entries; stall_cnt - full-stall counter
// Macro    : BRANCH_RS_STALL_CNT_EN - when defined, stall_cnt counts the
//            cycles with disp_valid && !disp_ready (saturating); when
//            undefined, stall_cnt is tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module branch_rs #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            disp_valid,
    output logic            disp_ready,
    input  logic [3:0]      disp_opcode,
    input  logic [3:0]      disp_rob,
    input  logic            disp_a_rdy,
    input  logic [3:0]      disp_a_tag,
    input  logic [XLEN-1:0] disp_a_val,
    input  logic            disp_t_rdy,
    input  logic [3:0]      disp_t_tag,
    input  logic [XLEN-1:0] disp_t_val,
    input  logic            cdb_valid,
    input  logic [3:0]      cdb_tag,
    input  logic [XLEN-1:0] cdb_data,
    input  logic            flush,
    output logic            iss_valid,
    output logic [3:0]      iss_opcode,
    output logic [3:0]      iss_rob,
    output logic [XLEN-1:0] iss_va,
    output logic [XLEN-1:0] iss_vt,
    output logic [3:0]      count,
    output logic [15:0]     stall_cnt
);

    localparam int         c_IW    = $clog2(DEPTH);
    localparam logic [3:0] c_DEPTH = 4'(DEPTH);

    // Stored state; an entry is valid when its index is below r_count.
    logic [3:0]      r_op    [DEPTH];
    logic [3:0]      r_rob   [DEPTH];
    logic            r_a_rdy [DEPTH];
    logic [3:0]      r_a_tag [DEPTH];
    logic [XLEN-1:0] r_a_val [DEPTH];
    logic            r_t_rdy [DEPTH];
    logic [3:0]      r_t_tag [DEPTH];
    logic [XLEN-1:0] r_t_val [DEPTH];
    logic [3:0]      r_count;

    logic [3:0]      w_n_op    [DEPTH];
    logic [3:0]      w_n_rob   [DEPTH];
    logic            w_n_a_rdy [DEPTH];
    logic [3:0]      w_n_a_tag [DEPTH];
    logic [XLEN-1:0] w_n_a_val [DEPTH];
    logic            w_n_t_rdy [DEPTH];
    logic [3:0]      w_n_t_tag [DEPTH];
    logic [XLEN-1:0] w_n_t_val [DEPTH];
    logic [3:0]      w_n_count;
    logic [3:0]      w_cnt_after;

    logic            w_found;
    logic [c_IW-1:0] w_idx;
    logic            w_disp;
    logic            w_a_hit;
    logic            w_t_hit;

    assign disp_ready = (r_count < c_DEPTH);
    assign w_disp     = disp_valid && disp_ready && !flush;
    assign count      = r_count;

    // Bypass: a dispatched operand still waiting on the tag being broadcast
    // this cycle is captured directly instead of missing its wakeup.
    assign w_a_hit = cdb_valid && !disp_a_rdy && (disp_a_tag == cdb_tag);
    assign w_t_hit = cdb_valid && !disp_t_rdy && (disp_t_tag == cdb_tag);

    // Oldest ready entry: scan downward so the lowest index wins.
    always_comb begin
        w_found = 1'b0;
        w_idx   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if ((4'(i) < r_count) && r_a_rdy[i] && r_t_rdy[i]) begin
                w_found = 1'b1;
                w_idx   = c_IW'(i);
            end
        end
    end

    assign iss_valid  = w_found;
    assign iss_opcode = w_found ? r_op[w_idx]    : '0;
    assign iss_rob    = w_found ? r_rob[w_idx]   : '0;
    assign iss_va     = w_found ? r_a_val[w_idx] : '0;
    assign iss_vt     = w_found ? r_t_val[w_idx] : '0;

    // Next-state: collapse out the issued entry, apply wakeup, then append.
    always_comb begin
        for (int j = 0; j < DEPTH; j++) begin
            w_n_op[j]    = r_op[j];
            w_n_rob[j]   = r_rob[j];
            w_n_a_rdy[j] = r_a_rdy[j];
            w_n_a_tag[j] = r_a_tag[j];
            w_n_a_val[j] = r_a_val[j];
            w_n_t_rdy[j] = r_t_rdy[j];
            w_n_t_tag[j] = r_t_tag[j];
            w_n_t_val[j] = r_t_val[j];
        end
        for (int j = 0; j < DEPTH - 1; j++) begin
            if (w_found && (c_IW'(j) >= w_idx)) begin
                w_n_op[j]    = r_op[j+1];
                w_n_rob[j]   = r_rob[j+1];
                w_n_a_rdy[j] = r_a_rdy[j+1];
                w_n_a_tag[j] = r_a_tag[j+1];
                w_n_a_val[j] = r_a_val[j+1];
                w_n_t_rdy[j] = r_t_rdy[j+1];
                w_n_t_tag[j] = r_t_tag[j+1];
                w_n_t_val[j] = r_t_val[j+1];
            end
        end
        for (int j = 0; j < DEPTH; j++) begin
            if (cdb_valid && !w_n_a_rdy[j] && (w_n_a_tag[j] == cdb_tag)) begin
                w_n_a_rdy[j] = 1'b1;
                w_n_a_val[j] = cdb_data;
            end
            if (cdb_valid && !w_n_t_rdy[j] && (w_n_t_tag[j] == cdb_tag)) begin
                w_n_t_rdy[j] = 1'b1;
                w_n_t_val[j] = cdb_data;
            end
        end
        w_cnt_after = r_count - {3'b000, w_found};
        for (int j = 0; j < DEPTH; j++) begin
            if (w_disp && (4'(j) == w_cnt_after)) begin
                w_n_op[j]    = disp_opcode;
                w_n_rob[j]   = disp_rob;
                w_n_a_rdy[j] = disp_a_rdy | w_a_hit;
                w_n_a_tag[j] = disp_a_tag;
                w_n_a_val[j] = w_a_hit ? cdb_data : disp_a_val;
                w_n_t_rdy[j] = disp_t_rdy | w_t_hit;
                w_n_t_tag[j] = disp_t_tag;
                w_n_t_val[j] = w_t_hit ? cdb_data : disp_t_val;
            end
        end
        w_n_count = w_cnt_after + {3'b000, w_disp};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_op[i]    <= '0;
                r_rob[i]   <= '0;
                r_a_rdy[i] <= 1'b0;
                r_a_tag[i] <= '0;
                r_a_val[i] <= '0;
                r_t_rdy[i] <= 1'b0;
                r_t_tag[i] <= '0;
                r_t_val[i] <= '0;
            end
        end else begin
            // Flush only needs to zero the count: entry contents beyond the
            // count are never observed.
            r_count <= flush ? 4'd0 : w_n_count;
            for (int i = 0; i < DEPTH; i++) begin
                r_op[i]    <= w_n_op[i];
                r_rob[i]   <= w_n_rob[i];
                r_a_rdy[i] <= w_n_a_rdy[i];
                r_a_tag[i] <= w_n_a_tag[i];
                r_a_val[i] <= w_n_a_val[i];
                r_t_rdy[i] <= w_n_t_rdy[i];
                r_t_tag[i] <= w_n_t_tag[i];
                r_t_val[i] <= w_n_t_val[i];
            end
        end
    end

`ifdef BRANCH_RS_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (disp_valid && !disp_ready && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`else
    assign stall_cnt = 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_branch_rs.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_rs
// Purpose  : Self-checking bench for branch_rs. A queue-based reference model
//            tracks the station contents; directed scenarios are followed by
//            randomized dispatch/CDB/flush traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_branch_rs;

    localparam int DEPTH = 4;
    localparam int XLEN  = 16;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            disp_valid;
    logic            disp_ready;
    logic [3:0]      disp_opcode;
    logic [3:0]      disp_rob;
    logic            disp_a_rdy;
    logic [3:0]      disp_a_tag;
    logic [XLEN-1:0] disp_a_val;
    logic            disp_t_rdy;
    logic [3:0]      disp_t_tag;
    logic [XLEN-1:0] disp_t_val;
    logic            cdb_valid;
    logic [3:0]      cdb_tag;
    logic [XLEN-1:0] cdb_data;
    logic            flush;
    logic            iss_valid;
    logic [3:0]      iss_opcode;
    logic [3:0]      iss_rob;
    logic [XLEN-1:0] iss_va;
    logic [XLEN-1:0] iss_vt;
    logic [3:0]      count;
    logic [15:0]     stall_cnt;

    branch_rs #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk(clk), .rst_n(rst_n),
        .disp_valid(disp_valid), .disp_ready(disp_ready),
        .disp_opcode(disp_opcode), .disp_rob(disp_rob),
        .disp_a_rdy(disp_a_rdy), .disp_a_tag(disp_a_tag), .disp_a_val(disp_a_val),
        .disp_t_rdy(disp_t_rdy), .disp_t_tag(disp_t_tag), .disp_t_val(disp_t_val),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .flush(flush),
        .iss_valid(iss_valid), .iss_opcode(iss_opcode), .iss_rob(iss_rob),
        .iss_va(iss_va), .iss_vt(iss_vt),
        .count(count), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]      op;
        logic [3:0]      rob;
        logic            ar;
        logic [3:0]      at;
        logic [XLEN-1:0] av;
        logic            tr;
        logic [3:0]      tt;
        logic [XLEN-1:0] tv;
    } ent_t;

    ent_t        q[$];
    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_stall = 16'd0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        disp_valid = 0; disp_opcode = 0; disp_rob = 0;
        disp_a_rdy = 0; disp_a_tag = 0; disp_a_val = 0;
        disp_t_rdy = 0; disp_t_tag = 0; disp_t_val = 0;
        cdb_valid = 0; cdb_tag = 0; cdb_data = 0; flush = 0;
    endtask

    task automatic disp(input logic [3:0] op, input logic [3:0] rob,
                        input logic ar, input logic [3:0] at, input logic [XLEN-1:0] av,
                        input logic tr, input logic [3:0] tt, input logic [XLEN-1:0] tv);
        disp_valid = 1; disp_opcode = op; disp_rob = rob;
        disp_a_rdy = ar; disp_a_tag = at; disp_a_val = av;
        disp_t_rdy = tr; disp_t_tag = tt; disp_t_val = tv;
    endtask

    task automatic cdb(input logic [3:0] tag, input logic [XLEN-1:0] data);
        cdb_valid = 1; cdb_tag = tag; cdb_data = data;
    endtask

    // Compare outputs against the model, then advance the model by one edge.
    task automatic cycle();
        int   idx;
        bit   rdy;
        ent_t e;
        #1;
        idx = -1;
        foreach (q[i]) if (idx < 0 && q[i].ar && q[i].tr) idx = i;
        rdy = (q.size() < DEPTH);
        check("count", 32'(count), 32'(q.size()));
        check("disp_ready", 32'(disp_ready), 32'(rdy));
        check("iss_valid", 32'(iss_valid), 32'(idx >= 0));
        check("iss_opcode", 32'(iss_opcode), (idx >= 0) ? 32'(q[idx].op) : 32'd0);
        check("iss_rob", 32'(iss_rob), (idx >= 0) ? 32'(q[idx].rob) : 32'd0);
        check("iss_va", 32'(iss_va), (idx >= 0) ? 32'(q[idx].av) : 32'd0);
        check("iss_vt", 32'(iss_vt), (idx >= 0) ? 32'(q[idx].tv) : 32'd0);
        check("stall_cnt", 32'(stall_cnt), 32'(exp_stall));
`ifdef BRANCH_RS_STALL_CNT_EN
        if (disp_valid && !rdy && exp_stall != 16'hFFFF) exp_stall++;
`endif
        if (flush) begin
            q.delete();
        end else begin
            if (idx >= 0) q.delete(idx);
            foreach (q[i]) begin
                if (cdb_valid && !q[i].ar && q[i].at == cdb_tag) begin q[i].ar = 1; q[i].av = cdb_data; end
                if (cdb_valid && !q[i].tr && q[i].tt == cdb_tag) begin q[i].tr = 1; q[i].tv = cdb_data; end
            end
            if (disp_valid && rdy) begin
                e.op = disp_opcode; e.rob = disp_rob;
                e.at = disp_a_tag; e.tt = disp_t_tag;
                e.ar = disp_a_rdy || (cdb_valid && disp_a_tag == cdb_tag);
                e.av = (!disp_a_rdy && cdb_valid && disp_a_tag == cdb_tag) ? cdb_data : disp_a_val;
                e.tr = disp_t_rdy || (cdb_valid && disp_t_tag == cdb_tag);
                e.tv = (!disp_t_rdy && cdb_valid && disp_t_tag == cdb_tag) ? cdb_data : disp_t_val;
                q.push_back(e);
            end
        end
        @(posedge clk);
        @(negedge clk);
        idle();
    endtask

    initial begin
        int k;
        idle();
        rst_n = 0;
        #2;
        check("rst_count", 32'(count), 0);
        check("rst_disp_ready", 32'(disp_ready), 1);
        check("rst_iss_valid", 32'(iss_valid), 0);
        check("rst_iss_fields", {iss_opcode, iss_rob, iss_va, 8'h0} | 32'(iss_vt), 0);
        check("rst_stall", 32'(stall_cnt), 0);
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);

        // Single ready jz issues the cycle after dispatch.
        disp(4'b1000, 4'd3, 1, 4'd0, 16'h0000, 1, 4'd0, 16'h0040);
        cycle();
        check("d1_iss_valid", 32'(iss_valid), 1);
        check("d1_iss_rob", 32'(iss_rob), 3);
        check("d1_iss_vt", 32'(iss_vt), 32'h40);
        cycle();
        check("d1_count", 32'(count), 0);

        // Younger ready entry bypasses an older waiting one.
        disp(4'b1001, 4'd1, 0, 4'd5, 16'h0000, 1, 4'd0, 16'h0100);
        cycle();
        disp(4'b1010, 4'd2, 1, 4'd0, 16'h0011, 1, 4'd0, 16'h0200);
        cycle();
        cdb(4'd5, 16'd7);
        check("d2_first_rob", 32'(iss_rob), 2);
        cycle();
        check("d2_second_rob", 32'(iss_rob), 1);
        check("d2_second_va", 32'(iss_va), 7);
        cycle();
        cycle();

        // Fill with waiting entries, then hold dispatch against a full station.
        for (int i = 0; i < DEPTH; i++) begin
            disp(4'b1011, 4'(i), 0, 4'(i + 1), 16'h0, 1, 4'd0, 16'h0);
            cycle();
        end
        for (int i = 0; i < 3; i++) begin
            disp(4'b1000, 4'd9, 1, 4'd0, 16'h0, 1, 4'd0, 16'h0);
            check("d3_full_ready", 32'(disp_ready), 0);
            check("d3_full_count", 32'(count), DEPTH);
            cycle();
        end
`ifdef BRANCH_RS_STALL_CNT_EN
        check("d3_stall", 32'(stall_cnt), 3);
`endif
        flush = 1;
        cycle();

        // Dispatch-cycle CDB bypass.
        disp(4'b1000, 4'd6, 0, 4'd9, 16'h0, 1, 4'd0, 16'h0055);
        cdb(4'd9, 16'h1234);
        cycle();
        check("d4_iss_valid", 32'(iss_valid), 1);
        check("d4_iss_va", 32'(iss_va), 32'h1234);
        cycle();

        // Flush overrides a same-cycle dispatch; later wakeup finds nothing.
        for (int i = 0; i < 3; i++) begin
            disp(4'b1001, 4'(i + 4), 0, 4'd6, 16'h0, 1, 4'd0, 16'h0);
            cycle();
        end
        disp(4'b1000, 4'd12, 1, 4'd0, 16'h0, 1, 4'd0, 16'h0);
        flush = 1;
        cycle();
        check("d5_count", 32'(count), 0);
        cdb(4'd6, 16'h0abc);
        cycle();
        check("d5_no_issue", 32'(iss_valid), 0);

        // Asynchronous reset between edges.
        disp(4'b1000, 4'd1, 0, 4'd2, 16'h0, 1, 4'd0, 16'h0);
        cycle();
        disp(4'b1000, 4'd2, 0, 4'd2, 16'h0, 1, 4'd0, 16'h0);
        cycle();
        check("d6_pre_count", 32'(count), 2);
        #2;
        rst_n = 0;
        #1;
        check("d6_count", 32'(count), 0);
        check("d6_iss_valid", 32'(iss_valid), 0);
        check("d6_disp_ready", 32'(disp_ready), 1);
        q.delete();
        exp_stall = 0;
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);

        // Randomized traffic.
        for (int n = 0; n < 500; n++) begin
            if ($urandom_range(0, 9) < 6)
                disp(4'(8 + $urandom_range(0, 3)), 4'($urandom), $urandom_range(0, 1) == 1,
                     4'($urandom), 16'($urandom), $urandom_range(0, 1) == 1,
                     4'($urandom), 16'($urandom));
            if ($urandom_range(0, 1) == 1) begin
                if (q.size() > 0 && $urandom_range(0, 3) != 0) begin
                    k = $urandom_range(0, q.size() - 1);
                    cdb($urandom_range(0, 1) ? q[k].at : q[k].tt, 16'($urandom));
                end else begin
                    cdb(4'($urandom), 16'($urandom));
                end
            end
            if ($urandom_range(0, 39) == 0) flush = 1;
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/branch_rs.md
BRANCH_RS -- requirements
Module: branch_rs

Interface
REQ-001 Parameter DEPTH, default 4; the number of station entries; legal range 2..8.
REQ-002 Parameter XLEN, default 16; the operand and target width.
REQ-003 clk  input  1  The single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  Asynchronous active-low reset.
REQ-005 disp_valid  input  1  A dispatch request is present.
REQ-006 disp_ready  output  1  The station can accept a dispatch this cycle.
REQ-007 disp_opcode  input  4  Branch opcode: 1000 jz, 1001 jnz, 1010 js, 1011 jns.
REQ-008 disp_rob  input  4  ROB index of the branch.
REQ-009 disp_a_rdy / disp_a_tag / disp_a_val  input  1/4/XLEN  Operand a: ready flag, producer ROB tag, value.
REQ-010 disp_t_rdy / disp_t_tag / disp_t_val  input  1/4/XLEN  Target operand t: ready flag, producer ROB tag, value.
REQ-011 cdb_valid / cdb_tag / cdb_data  input  1/4/XLEN  Common data bus broadcast.
REQ-012 flush  input  1  Squash all entries.
REQ-013 iss_valid  output  1  An issue to the branch unit occurs this cycle.
REQ-014 iss_opcode / iss_rob / iss_va / iss_vt  output  4/4/XLEN/XLEN  The issued branch fields.
REQ-015 count  output  4  The number of occupied entries.
REQ-016 stall_cnt  output  16  The full-stall counter (see Configuration).

Function
REQ-017 The station SHALL be a collapsing queue: entry 0 is oldest; new entries append at index count.
REQ-018 disp_ready SHALL equal (count < DEPTH), derived from registered state only; it has no dependency on same-cycle issue.
REQ-019 A dispatch SHALL occur when disp_valid && disp_ready && !flush.
REQ-020 An entry is ready when both its operand ready flags are set.
REQ-021 iss_valid SHALL assert combinationally when any stored entry is ready; it selects the lowest-index ready entry; iss_* carry that entry's fields.
REQ-022 The issued entry SHALL be removed at the clock edge; younger entries shift down by one, preserving order.
REQ-023 Dispatch and issue in the same cycle SHALL both take effect; count is unchanged and the new entry lands at index count-1.
REQ-024 Wakeup: on cdb_valid, every stored operand with ready=0 and tag==cdb_tag SHALL set ready=1 and capture cdb_data at that edge.
REQ-025 Dispatch bypass: a dispatched operand with rdy=0 whose tag matches a same-cycle valid CDB tag SHALL be written as ready with cdb_data.
REQ-026 A newly dispatched entry SHALL not issue in its dispatch cycle; minimum dispatch-to-issue latency is 1 cycle.
REQ-027 A CDB broadcast that wakes an entry in cycle N SHALL make it issuable in cycle N+1, not N.
REQ-028 flush SHALL clear all entries at the edge; count becomes 0; flush overrides dispatch, issue removal, and wakeup.
REQ-029 iss_valid SHALL still reflect pre-flush state in the flush cycle; the consumer qualifies it with flush.
REQ-030 When count==0, iss_valid=0 and iss_* SHALL be driven to 0.
REQ-031 Operand values SHALL be held unmodified (XLEN bits, no extension or truncation).

Reset
REQ-032 While rst_n=0: all entries are invalid; count=0; stall_cnt=0; disp_ready=1; iss_valid=0; iss_* are 0.
REQ-033 Reset asserted mid-operation SHALL discard all entries immediately, without waiting for a clock edge.
REQ-034 Deassertion SHALL take effect at the next clk edge with an empty station.

Configuration
REQ-035 Macro BRANCH_RS_STALL_CNT_EN defined: stall_cnt increments, saturating at 16'hFFFF, each cycle with disp_valid && !disp_ready; it clears on reset only.
REQ-036 Macro BRANCH_RS_STALL_CNT_EN undefined: stall_cnt is tied to 0 and no counter register exists.

Verification
REQ-037 Dispatch jz, rob=3, both operands ready, a=0, t=16'h0040 -> iss_valid=1 next cycle with iss_rob=3, iss_va=0, iss_vt=16'h0040; count returns to 0.
REQ-038 Dispatch rob=1 with a waiting on tag 5, then rob=2 with both ready; CDB tag 5 data 7 -> rob=2 issues first; rob=1 issues the cycle after the CDB with iss_va=7.
REQ-039 Fill 4 entries, none ready, hold disp_valid -> disp_ready=0 and count=4; with the macro defined, stall_cnt increments by 1 per stalled cycle.
REQ-040 Dispatch with a_tag=9 in the same cycle as CDB tag 9 data 16'h1234 -> the entry is stored ready with va=16'h1234 and issues next cycle.
REQ-041 Three waiting entries, assert flush together with disp_valid -> count=0 the next cycle, the dispatch is dropped, and a later CDB produces no issue.
REQ-042 Pull rst_n low between clock edges with count=2 -> count=0, iss_valid=0, disp_ready=1 immediately.
